// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller: host FSM states,
// word width and the partial-store lane mask.
package dmem_pkg;

   localparam int WORD_W = 32;
   localparam int LANES  = WORD_W / 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      FIN   = 2'd2
   } host_state_t;

   // Bit i of the mask enables byte lane i; lane 0 is the most significant byte.
   function automatic logic [LANES-1:0] lane_mask(input logic [1:0] addr,
                                                  input logic       write_l,
                                                  input logic       write_r);
      logic [LANES-1:0] mask;
      mask = '1;
      for (int i = 0; i < LANES; i++) begin
         if (write_l && !write_r) begin
            mask[i] = (i >= int'(addr));
         end else if (write_r && !write_l) begin
            mask[i] = (i <= int'(addr));
         end
      end
      return mask;
   endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous data RAM with per-lane write enables; a read in the
// same cycle as a write returns the newly written word.
module dmem_ram
   import dmem_pkg::*;
#(
   parameter int AW = 14
) (
   input  logic              Clock,
   input  logic              en,
   input  logic [LANES-1:0]  we,
   input  logic [AW-1:0]     addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [2**AW];
   logic [WORD_W-1:0] word_d;
   logic [WORD_W-1:0] rdata_q;

   always_comb begin
      word_d = mem[addr];
      for (int i = 0; i < LANES; i++) begin
         if (we[i]) begin
            word_d[WORD_W-1-8*i -: 8] = wdata[WORD_W-1-8*i -: 8];
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (en) begin
         if (|we) begin
            mem[addr] <= word_d;
         end
         rdata_q <= word_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: processor loads/stores with one-cycle read latency and
// a host burst port using idle cycles. Host port compiled in with DMEM_HOST_EN.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int LEN_W  = 8
) (
   input  logic              Clock,
   input  logic              nReset,
   input  logic [ADDR_W-1:0] MemAddr,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [31:0]       WriteData,
   input  logic              WriteL,
   input  logic              WriteR,
   output logic [31:0]       MemData,
   input  logic              HostStart,
   input  logic              HostWrite,
   input  logic [ADDR_W-3:0] HostAddr,
   input  logic [LEN_W-1:0]  HostLen,
   input  logic              HostValid,
   input  logic [31:0]       HostWData,
   output logic              HostReady,
   output logic              HostRValid,
   output logic [31:0]       HostRData,
   output logic              HostBusy,
   output logic              HostDone
);

   localparam int WA = ADDR_W - 2;
   localparam int CW = LEN_W + 1;

   logic              proc_access;
   logic              proc_store;
   logic              slot;
   logic [WA-1:0]     proc_word;

   logic              ram_en;
   logic [LANES-1:0]  ram_we;
   logic [WA-1:0]     ram_addr;
   logic [WORD_W-1:0] ram_wdata;
   logic [WORD_W-1:0] ram_rdata;

   logic              host_issue;
   logic              host_wr;
   logic [WA-1:0]     host_word;

   logic              load_vld_q, load_vld_d;
   logic [WORD_W-1:0] mem_hold_q, mem_hold_d;

   assign proc_access = MemRead | MemWrite;
   assign proc_store  = MemWrite & ~MemRead;
   assign slot        = ~proc_access;
   assign proc_word   = MemAddr[ADDR_W-1:2];

   // The processor always owns the port when it asks; the host only gets idle slots.
   always_comb begin
      ram_en    = proc_access | host_issue;
      ram_addr  = proc_access ? proc_word : host_word;
      ram_we    = '0;
      ram_wdata = WriteData;
      if (proc_store) begin
         ram_we = lane_mask(MemAddr[1:0], WriteL, WriteR);
      end else if (host_issue && host_wr) begin
         ram_we    = '1;
         ram_wdata = HostWData;
      end
   end

   dmem_ram #(.AW(WA)) u_ram (
      .Clock (Clock),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   // RAM output is shared with host reads, so load data is held once returned.
   assign MemData = load_vld_q ? ram_rdata : mem_hold_q;

   always_comb begin
      load_vld_d = MemRead;
      mem_hold_d = MemData;
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         load_vld_q <= 1'b0;
         mem_hold_q <= '0;
      end else begin
         load_vld_q <= load_vld_d;
         mem_hold_q <= mem_hold_d;
      end
   end

`ifdef DMEM_HOST_EN

   host_state_t       state_q, state_d;
   logic [WA-1:0]     haddr_q, haddr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              dir_q, dir_d;
   logic              rvalid_q, rvalid_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic [WORD_W-1:0] rhold_q, rhold_d;
   logic              host_ready;

   assign host_wr   = dir_q;
   assign host_word = haddr_q;

   always_comb begin
      state_d    = state_q;
      haddr_d    = haddr_q;
      cnt_d      = cnt_q;
      dir_d      = dir_q;
      rvalid_d   = 1'b0;
      done_d     = 1'b0;
      host_ready = 1'b0;
      host_issue = 1'b0;
      rhold_d    = HostRData;
      case (state_q)
         IDLE: begin
            if (HostStart) begin
               haddr_d = HostAddr;
               dir_d   = HostWrite;
               cnt_d   = (HostLen == '0) ? CW'(1 << LEN_W) : CW'(HostLen);
               state_d = BURST;
            end
         end
         BURST: begin
            host_ready = dir_q & slot;
            host_issue = dir_q ? (slot & HostValid) : slot;
            if (host_issue) begin
               haddr_d  = haddr_q + WA'(1);
               cnt_d    = cnt_q - CW'(1);
               rvalid_d = ~dir_q;
               if (cnt_q == CW'(1)) begin
                  state_d = FIN;
                  done_d  = 1'b1;
               end
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_q  <= IDLE;
         haddr_q  <= '0;
         cnt_q    <= '0;
         dir_q    <= 1'b0;
         rvalid_q <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         rhold_q  <= '0;
      end else begin
         state_q  <= state_d;
         haddr_q  <= haddr_d;
         cnt_q    <= cnt_d;
         dir_q    <= dir_d;
         rvalid_q <= rvalid_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         rhold_q  <= rhold_d;
      end
   end

   assign HostReady  = host_ready;
   assign HostRValid = rvalid_q;
   assign HostRData  = rvalid_q ? ram_rdata : rhold_q;
   assign HostBusy   = busy_q;
   assign HostDone   = done_q;

`else

   logic unused_host;

   assign host_issue  = 1'b0;
   assign host_wr     = 1'b0;
   assign host_word   = '0;
   assign unused_host = ^{slot, HostStart, HostWrite, HostAddr, HostLen, HostValid, HostWData};

   assign HostReady  = 1'b0;
   assign HostRValid = 1'b0;
   assign HostRData  = '0;
   assign HostBusy   = 1'b0;
   assign HostDone   = 1'b0;

`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: table-driven processor vectors plus
// hand-written host burst sequences (host checks follow DMEM_HOST_EN).
module tb_dmem_ctrl;

   localparam int ADDR_W = 16;
   localparam int LEN_W  = 8;

   logic              Clock;
   logic              nReset;
   logic [ADDR_W-1:0] MemAddr;
   logic              MemRead;
   logic              MemWrite;
   logic [31:0]       WriteData;
   logic              WriteL;
   logic              WriteR;
   logic [31:0]       MemData;
   logic              HostStart;
   logic              HostWrite;
   logic [ADDR_W-3:0] HostAddr;
   logic [LEN_W-1:0]  HostLen;
   logic              HostValid;
   logic [31:0]       HostWData;
   logic              HostReady;
   logic              HostRValid;
   logic [31:0]       HostRData;
   logic              HostBusy;
   logic              HostDone;

   int nVectors     = 0;
   int nMiscompares = 0;

   typedef struct {
      logic [15:0] addr;
      logic        rd;
      logic        wr;
      logic        wl;
      logic        wrr;
      logic [31:0] wdata;
      logic        chk;
      logic [31:0] expData;
   } vec_t;

   vec_t vecs[$];

   dmem_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .Clock      (Clock),
      .nReset     (nReset),
      .MemAddr    (MemAddr),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .WriteData  (WriteData),
      .WriteL     (WriteL),
      .WriteR     (WriteR),
      .MemData    (MemData),
      .HostStart  (HostStart),
      .HostWrite  (HostWrite),
      .HostAddr   (HostAddr),
      .HostLen    (HostLen),
      .HostValid  (HostValid),
      .HostWData  (HostWData),
      .HostReady  (HostReady),
      .HostRValid (HostRValid),
      .HostRData  (HostRData),
      .HostBusy   (HostBusy),
      .HostDone   (HostDone)
   );

   // Free-running clock, 10 time units per period
   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Safety net so a stuck design still ends the run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mkVec(input logic [15:0] addr, input logic rd, input logic wr,
                                  input logic wl, input logic wrr, input logic [31:0] wdata,
                                  input logic chk, input logic [31:0] expData);
      vec_t v;
      v.addr    = addr;
      v.rd      = rd;
      v.wr      = wr;
      v.wl      = wl;
      v.wrr     = wrr;
      v.wdata   = wdata;
      v.chk     = chk;
      v.expData = expData;
      return v;
   endfunction

   // One comparison: counts it and reports any difference
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nVectors++;
      if (actual !== expected) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got %08h, expected %08h", name, actual, expected);
      end
   endtask

   // Drives one processor cycle from the negedge and checks MemData one cycle later
   task automatic applyStimulus(input vec_t v, input string name);
      MemAddr   = v.addr;
      MemRead   = v.rd;
      MemWrite  = v.wr;
      WriteL    = v.wl;
      WriteR    = v.wrr;
      WriteData = v.wdata;
      @(negedge Clock);
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      WriteL   = 1'b0;
      WriteR   = 1'b0;
      if (v.chk) begin
         checkOutput(name, MemData, v.expData);
      end
   endtask

`ifdef DMEM_HOST_EN
   // Known contents of the read-burst window that starts at word 0x3FFE
   function automatic bit knownWord(input int idx, output logic [31:0] w);
      bit known;
      known = 1'b1;
      case (idx)
         0:       w = 32'hB000_0000;
         1:       w = 32'hB000_0001;
         2:       w = 32'hB000_0002;
         3:       w = 32'hB000_0003;
         4:       w = 32'h5A5A_5A5A;
         6:       w = 32'hA1B2_C3D4;
         10:      w = 32'hAABB_3344;
         66:      w = 32'h1234_5678;
         67:      w = 32'h5566_7788;
         default: begin
            w     = '0;
            known = 1'b0;
         end
      endcase
      return known;
   endfunction
`endif

   // Main sequence: reset, processor table, then host sequences
   initial begin
      nReset    = 1'b0;
      MemAddr   = '0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      WriteData = '0;
      WriteL    = 1'b0;
      WriteR    = 1'b0;
      HostStart = 1'b0;
      HostWrite = 1'b0;
      HostAddr  = '0;
      HostLen   = '0;
      HostValid = 1'b0;
      HostWData = '0;

      vecs.push_back(mkVec(16'h0010, 0, 1, 0, 0, 32'hDEAD_BEEF, 0, 32'h0));
      vecs.push_back(mkVec(16'h0010, 1, 0, 0, 0, 32'h0,         1, 32'hDEAD_BEEF));
      vecs.push_back(mkVec(16'h0020, 0, 1, 0, 0, 32'h1122_3344, 0, 32'h0));
      vecs.push_back(mkVec(16'h0021, 0, 1, 1, 0, 32'hAABB_CCDD, 0, 32'h0));
      vecs.push_back(mkVec(16'h0020, 1, 0, 0, 0, 32'h0,         1, 32'h11BB_CCDD));
      vecs.push_back(mkVec(16'h0020, 0, 1, 0, 0, 32'h1122_3344, 0, 32'h0));
      vecs.push_back(mkVec(16'h0021, 0, 1, 0, 1, 32'hAABB_CCDD, 0, 32'h0));
      vecs.push_back(mkVec(16'h0020, 1, 0, 0, 0, 32'h0,         1, 32'hAABB_3344));
      vecs.push_back(mkVec(16'h0000, 0, 0, 0, 0, 32'h0,         1, 32'hAABB_3344));
      vecs.push_back(mkVec(16'h0100, 0, 1, 0, 0, 32'hCAFE_F00D, 0, 32'h0));
      vecs.push_back(mkVec(16'h0010, 1, 0, 0, 0, 32'h0,         1, 32'hDEAD_BEEF));
      vecs.push_back(mkVec(16'h0100, 1, 0, 0, 0, 32'h0,         1, 32'hCAFE_F00D));
      vecs.push_back(mkVec(16'h0103, 0, 1, 1, 0, 32'h0000_00EE, 0, 32'h0));
      vecs.push_back(mkVec(16'h0104, 0, 1, 0, 0, 32'h0102_0304, 0, 32'h0));
      vecs.push_back(mkVec(16'h0104, 0, 1, 0, 1, 32'h9900_0000, 0, 32'h0));
      vecs.push_back(mkVec(16'h0100, 1, 0, 0, 0, 32'h0,         1, 32'hCAFE_F0EE));
      vecs.push_back(mkVec(16'h0104, 1, 0, 0, 0, 32'h0,         1, 32'h9902_0304));
      vecs.push_back(mkVec(16'h0106, 0, 1, 1, 1, 32'h5566_7788, 0, 32'h0));
      vecs.push_back(mkVec(16'h0104, 1, 0, 0, 0, 32'h0,         1, 32'h5566_7788));
      vecs.push_back(mkVec(16'h0100, 0, 1, 1, 0, 32'h1234_5678, 0, 32'h0));
      vecs.push_back(mkVec(16'h0013, 0, 1, 0, 1, 32'hA1B2_C3D4, 0, 32'h0));
      vecs.push_back(mkVec(16'h0100, 1, 0, 0, 0, 32'h0,         1, 32'h1234_5678));
      vecs.push_back(mkVec(16'h0010, 1, 0, 0, 0, 32'h0,         1, 32'hA1B2_C3D4));
      vecs.push_back(mkVec(16'h0000, 0, 0, 0, 0, 32'h0,         1, 32'hA1B2_C3D4));

      repeat (2) @(negedge Clock);
      nReset = 1'b1;
      #1;
      checkOutput("rst_memdata",   MemData,            32'h0);
      checkOutput("rst_hostrdata", HostRData,          32'h0);
      checkOutput("rst_ready",     32'(HostReady),     32'h0);
      checkOutput("rst_rvalid",    32'(HostRValid),    32'h0);
      checkOutput("rst_busy",      32'(HostBusy),      32'h0);
      checkOutput("rst_done",      32'(HostDone),      32'h0);
      @(negedge Clock);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i], $sformatf("vec%0d", i));
      end

      applyStimulus(mkVec(16'h0008, 0, 1, 0, 0, 32'h5A5A_5A5A, 0, 32'h0), "prewrite");

`ifdef DMEM_HOST_EN
      // Write burst of 4 words across the top of memory, loads on alternate cycles
      begin : write_burst
         int          k;
         bit          expReady, doneExp, busyExp, nextDone, nextBusy;
         logic [31:0] expMem;
         HostStart = 1'b1;
         HostWrite = 1'b1;
         HostAddr  = 14'h3FFE;
         HostLen   = 8'd4;
         HostValid = 1'b1;
         HostWData = 32'hB000_0000;
         @(negedge Clock);
         k       = 0;
         doneExp = 1'b0;
         busyExp = 1'b1;
         expMem  = 32'hA1B2_C3D4;
         for (int c = 0; c < 12; c++) begin
            MemRead   = (c % 2 == 1);
            MemAddr   = (c % 4 == 1) ? 16'h0100 : 16'h0010;
            HostStart = (c == 3);
            HostAddr  = (c == 3) ? 14'h0100 : 14'h3FFE;
            HostWData = 32'hB000_0000 + 32'(k);
            #1;
            expReady = (k < 4) && !MemRead;
            checkOutput($sformatf("wr_ready_c%0d", c),   32'(HostReady), 32'(expReady));
            checkOutput($sformatf("wr_done_c%0d", c),    32'(HostDone),  32'(doneExp));
            checkOutput($sformatf("wr_busy_c%0d", c),    32'(HostBusy),  32'(busyExp));
            checkOutput($sformatf("wr_memdata_c%0d", c), MemData,        expMem);
            nextDone = expReady && (k == 3);
            nextBusy = busyExp && !doneExp;
            if (expReady) k++;
            doneExp = nextDone;
            busyExp = nextBusy;
            if (MemRead) expMem = (MemAddr == 16'h0100) ? 32'h1234_5678 : 32'hA1B2_C3D4;
            @(negedge Clock);
         end
         MemRead   = 1'b0;
         HostStart = 1'b0;
         HostValid = 1'b0;
      end

      applyStimulus(mkVec(16'hFFF8, 1, 0, 0, 0, 32'h0, 1, 32'hB000_0000), "wrap_w3ffe");
      applyStimulus(mkVec(16'hFFFC, 1, 0, 0, 0, 32'h0, 1, 32'hB000_0001), "wrap_w3fff");
      applyStimulus(mkVec(16'h0000, 1, 0, 0, 0, 32'h0, 1, 32'hB000_0002), "wrap_w0000");
      applyStimulus(mkVec(16'h0004, 1, 0, 0, 0, 32'h0, 1, 32'hB000_0003), "wrap_w0001");
      applyStimulus(mkVec(16'h0008, 1, 0, 0, 0, 32'h0, 1, 32'h5A5A_5A5A), "no_overrun");

      // Full 256-word read burst with a processor load every third cycle
      begin : read_burst
         int          issued, prevIdx, pulses, doneCount;
         bit          prevIssue, issue, finished;
         logic [31:0] expw;
         HostStart = 1'b1;
         HostWrite = 1'b0;
         HostAddr  = 14'h3FFE;
         HostLen   = 8'd0;
         @(negedge Clock);
         HostStart = 1'b0;
         issued    = 0;
         prevIdx   = 0;
         pulses    = 0;
         doneCount = 0;
         prevIssue = 1'b0;
         finished  = 1'b0;
         for (int c = 0; c < 600 && !finished; c++) begin
            MemRead = (c % 3 == 2);
            MemAddr = 16'h0010;
            #1;
            checkOutput("rd_valid", 32'(HostRValid), 32'(prevIssue));
            checkOutput("rd_done",  32'(HostDone),   32'(prevIssue && issued == 256));
            if (prevIssue) begin
               pulses++;
               if (knownWord(prevIdx, expw)) begin
                  checkOutput($sformatf("rd_data%0d", prevIdx), HostRData, expw);
               end
            end
            if (HostDone) doneCount++;
            if (prevIssue && issued == 256) finished = 1'b1;
            issue     = (issued < 256) && !MemRead;
            prevIdx   = issued;
            prevIssue = issue;
            if (issue) issued++;
            @(negedge Clock);
         end
         MemRead = 1'b0;
         checkOutput("rd_pulses",     32'(pulses),    32'd256);
         checkOutput("rd_done_count", 32'(doneCount), 32'd1);
         checkOutput("rd_busy_after", 32'(HostBusy),  32'h0);
      end

      // Reset lands after two of eight host writes
      for (int i = 0; i < 8; i++) begin
         applyStimulus(mkVec(16'h0800 + 16'(4 * i), 0, 1, 0, 0, 32'h7777_7777, 0, 32'h0), "fill");
      end
      applyStimulus(mkVec(16'h0010, 1, 0, 0, 0, 32'h0, 1, 32'hA1B2_C3D4), "pre_rst_load");
      HostStart = 1'b1;
      HostWrite = 1'b1;
      HostAddr  = 14'h0200;
      HostLen   = 8'd8;
      HostValid = 1'b1;
      HostWData = 32'hC000_0000;
      @(negedge Clock);
      HostStart = 1'b0;
      @(negedge Clock);
      HostWData = 32'hC000_0001;
      @(negedge Clock);
      HostWData = 32'hC000_0002;
      nReset    = 1'b0;
      #1;
      checkOutput("mid_rst_memdata", MemData,         32'h0);
      checkOutput("mid_rst_rdata",   HostRData,       32'h0);
      checkOutput("mid_rst_ready",   32'(HostReady),  32'h0);
      checkOutput("mid_rst_rvalid",  32'(HostRValid), 32'h0);
      checkOutput("mid_rst_busy",    32'(HostBusy),   32'h0);
      checkOutput("mid_rst_done",    32'(HostDone),   32'h0);
      repeat (2) @(negedge Clock);
      nReset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         checkOutput($sformatf("post_rst_busy_c%0d", c),  32'(HostBusy),  32'h0);
         checkOutput($sformatf("post_rst_ready_c%0d", c), 32'(HostReady), 32'h0);
         @(negedge Clock);
      end
      HostValid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(mkVec(16'h0800 + 16'(4 * i), 1, 0, 0, 0, 32'h0, 1,
                             (i == 0) ? 32'hC000_0000 : (i == 1) ? 32'hC000_0001 : 32'h7777_7777),
                       $sformatf("rst_word%0d", i));
      end
`else
      // Host port absent: a write burst request must have no visible effect
      HostStart = 1'b1;
      HostWrite = 1'b1;
      HostAddr  = 14'h0002;
      HostLen   = 8'd2;
      HostValid = 1'b1;
      HostWData = 32'hFFFF_FFFF;
      for (int c = 0; c < 6; c++) begin
         #1;
         checkOutput($sformatf("off_ready_c%0d", c),  32'(HostReady),  32'h0);
         checkOutput($sformatf("off_busy_c%0d", c),   32'(HostBusy),   32'h0);
         checkOutput($sformatf("off_done_c%0d", c),   32'(HostDone),   32'h0);
         checkOutput($sformatf("off_rvalid_c%0d", c), 32'(HostRValid), 32'h0);
         checkOutput($sformatf("off_rdata_c%0d", c),  HostRData,       32'h0);
         @(negedge Clock);
         HostStart = 1'b0;
      end
      HostValid = 1'b0;
      applyStimulus(mkVec(16'h0008, 1, 0, 0, 0, 32'h0, 1, 32'h5A5A_5A5A), "off_untouched");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
